game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Top-level game sequencer between the keyboard inputs and the VGA renderer. It owns the game state machine (menu, play, pause, game over) and the player position, lives and score registers. It advances all game logic once per video frame using a frame_tick pulse from the VGA timing block. The renderer reads its registered outputs to draw each frame.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PLAYER_SIZE, 16, player sprite edge length in pixels
STEP, 4, pixels moved per movement update
MOVE_DIV, 2, frame_ticks per movement update (>=1)
LIVES, 3, lives loaded at new game (1..7)
INVULN_FRAMES, 60, frames after a hit during which further hits are ignored

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
key_w  input  1  up key level, already synchronised to clk
key_a  input  1  left key level
key_s  input  1  down key level
key_d  input  1  right key level
key_esc  input  1  pause/back key level
key_enter  input  1  start/confirm key level
frame_tick  input  1  one-cycle pulse at start of vertical blank
hit  input  1  one-cycle collision pulse from renderer
state  output  2  0=MENU 1=PLAY 2=PAUSE 3=OVER
player_x  output  10  sprite left edge
player_y  output  10  sprite top edge
lives  output  3  remaining lives
score  output  16  frames survived, saturating
invuln  output  1  high while the invulnerability counter is non-zero
new_game  output  1  one-cycle pulse when a game starts

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- All outputs are registered. Each takes effect the cycle after its causing input.
- Reset values:
  - state=MENU.
  - player_x=(SCREEN_W-PLAYER_SIZE)/2 and player_y=(SCREEN_H-PLAYER_SIZE)/2.
  - lives=0, score=0, invuln=0, new_game=0.
  - Frame divider and invulnerability counter cleared.
- Esc/enter presses are rising edges: key & ~prev. The prev registers reset to 1, so a key held through reset does not fire.
- MENU:
  - enter press -> PLAY.
  - Same transition reloads the centre position, sets lives=LIVES, clears score, divider and invulnerability counter, and pulses new_game.
  - esc ignored.
- PLAY, handled in this priority order within one cycle:
  - On hit with invuln=0: lives decrements and the invulnerability counter is loaded with INVULN_FRAMES. If lives was 1, next state is OVER; this overrides a same-cycle esc.
  - Otherwise esc press -> PAUSE.
  - On frame_tick:
    - score increments, saturating at 0xFFFF.
    - invulnerability counter decrements if non-zero.
    - divider increments. When it reaches MOVE_DIV-1 it wraps to 0 and a movement update occurs.
  - hit and frame_tick in the same cycle are both processed.
- Movement update:
  - W: y-=STEP. S: y+=STEP. A: x-=STEP. D: x+=STEP.
  - Both opposing keys held: that axis does not move.
  - Results clamp to [0, SCREEN_W-PLAYER_SIZE] and [0, SCREEN_H-PLAYER_SIZE].
  - Arithmetic uses 11-bit signed intermediates, so underflow below 0 clamps to 0.
- PAUSE:
  - esc or enter press -> PLAY.
  - frame_tick, hit and movement keys ignored.
  - Divider and counters frozen.
- OVER:
  - enter or esc press -> MENU.
  - Position, lives and score hold, so the final score stays visible.
- Reset mid-game returns to the reset values immediately. No partial state survives.

Optional Feature:
GAME_CTRL_WRAP_EN
- Defined: the player wraps around the screen edges instead of clamping.
  - Stepping below 0 gives the limit minus the overshoot.
  - Stepping beyond the limit gives the overshoot beyond the limit.
- Undefined: clamping as specified above.

Decomposition:
- Shared package game_pkg holds:
  - the game_state_t enum (MENU, PLAY, PAUSE, OVER);
  - the SCREEN_W and SCREEN_H constants;
  - the coordinate width constant (10).
- One sub-module, key_edge: a parameterised-width rising-edge detector with prev registers resetting to 1. It is used for esc/enter and is reusable by other blocks.

Test Plan:
- Reset with key_enter held high, then keep it held -> no PLAY transition. Release then press -> state=PLAY next cycle, new_game pulses once, lives=3, position=(312,232).
- In PLAY hold key_d with MOVE_DIV=2, send 10 frame_ticks -> player_x=332, score=10. Hold key_a at x=0 for 4 ticks -> x stays 0. With GAME_CTRL_WRAP_EN, x=0 stepping left -> 620.
- Hold key_w and key_s together for 4 ticks -> player_y unchanged.
- Send hit, then another hit 5 frames later -> lives=2 and invuln=1. After 60 ticks invuln=0; the next hit gives lives=1.
- lives=1: hit and esc press in the same cycle -> state=OVER, not PAUSE. Enter press -> MENU with score held until the next game.
- In PLAY press esc -> PAUSE. Send frame_ticks, hits and key_d -> score, lives and position unchanged. Press enter -> PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and screen constants for the game controller and its renderer.
package game_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for a bus of synchronised key levels; press = key & ~prev.
module key_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key,
    output logic [W-1:0] press
);

    logic [W-1:0] prev;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    // prev resets high so a key already held across reset never reads as a press.
    always_ff @(posedge clk) begin
        if (rst) prev <= '1;
        else     prev <= key;
    end

    assign press = key & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: menu/play/pause/over FSM plus player position, lives, score.
// Define GAME_CTRL_WRAP_EN to wrap the player around screen edges instead of clamping.
module game_ctrl
    import game_pkg::*;
#(
    parameter int PLAYER_SIZE   = 16,
    parameter int STEP          = 4,
    parameter int MOVE_DIV      = 2,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_w,
    input  logic               key_a,
    input  logic               key_s,
    input  logic               key_d,
    input  logic               key_esc,
    input  logic               key_enter,
    input  logic               frame_tick,
    input  logic               hit,
    output logic [1:0]         state,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic [2:0]         lives,
    output logic [15:0]        score,
    output logic               invuln,
    output logic               new_game
);

    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);

    localparam logic [COORD_W-1:0]        X_CTR  = COORD_W'((SCREEN_W - PLAYER_SIZE) / 2);
    localparam logic [COORD_W-1:0]        Y_CTR  = COORD_W'((SCREEN_H - PLAYER_SIZE) / 2);
    localparam logic signed [COORD_W:0]   X_LIM  = (COORD_W+1)'(SCREEN_W - PLAYER_SIZE);
    localparam logic signed [COORD_W:0]   Y_LIM  = (COORD_W+1)'(SCREEN_H - PLAYER_SIZE);
    localparam logic signed [COORD_W:0]   STEP_S = (COORD_W+1)'(STEP);
    localparam logic [DIV_W-1:0]          DIV_LAST = DIV_W'(MOVE_DIV - 1);

    // One axis of a movement update; the extra sign bit lets underflow be seen.
    function automatic logic [COORD_W-1:0] step_axis(
        input logic [COORD_W-1:0]      pos,
        input logic                    dec,
        input logic                    inc,
        input logic signed [COORD_W:0] lim
    );
        logic signed [COORD_W:0] p;
        p = signed'({1'b0, pos});
        if (inc && !dec)      p = p + STEP_S;
        else if (dec && !inc) p = p - STEP_S;
`ifdef GAME_CTRL_WRAP_EN
        if (p[COORD_W])  p = lim + p;
        else if (p > lim) p = p - lim;
`else
        if (p[COORD_W])  p = '0;
        else if (p > lim) p = lim;
`endif
        return p[COORD_W-1:0];
    endfunction

    logic [1:0] key_press;
    logic       esc_press;
    logic       enter_press;

    key_edge #(.W(2)) u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .key   ({key_enter, key_esc}),
        .press (key_press)
    );

    assign esc_press   = key_press[0];
    assign enter_press = key_press[1];

    game_state_t        state_r, state_n;
    logic [COORD_W-1:0] x_n, y_n;
    logic [2:0]         lives_n;
    logic [15:0]        score_n;
    logic [INV_W-1:0]   inv_cnt, inv_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic               new_game_n;
    logic               hit_ok;

    assign hit_ok = hit && (inv_cnt == '0);
    assign state  = state_r;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n    = state_r;
        x_n        = player_x;
        y_n        = player_y;
        lives_n    = lives;
        score_n    = score;
        inv_n      = inv_cnt;
        div_n      = div_cnt;
        new_game_n = 1'b0;

        case (state_r)
            MENU: begin
                if (enter_press) begin
                    state_n    = PLAY;
                    x_n        = X_CTR;
                    y_n        = Y_CTR;
                    lives_n    = 3'(LIVES);
                    score_n    = '0;
                    inv_n      = '0;
                    div_n      = '0;
                    new_game_n = 1'b1;
                end
            end
            PLAY: begin
                if (hit_ok) begin
                    lives_n = lives - 3'd1;
                    inv_n   = INV_W'(INVULN_FRAMES);
                end
                // Losing the last life wins over a same-cycle pause request.
                if (hit_ok && lives == 3'd1) state_n = OVER;
                else if (esc_press)          state_n = PAUSE;

                if (frame_tick) begin
                    if (score != 16'hFFFF) score_n = score + 16'd1;
                    if (inv_cnt != '0)     inv_n   = inv_cnt - INV_W'(1);
                    if (div_cnt == DIV_LAST) begin
                        div_n = '0;
                        x_n   = step_axis(player_x, key_a, key_d, X_LIM);
                        y_n   = step_axis(player_y, key_w, key_s, Y_LIM);
                    end else begin
                        div_n = div_cnt + DIV_W'(1);
                    end
                end
            end
            PAUSE: begin
                if (esc_press || enter_press) state_n = PLAY;
            end
            OVER: begin
                if (esc_press || enter_press) state_n = MENU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= MENU;
            player_x <= X_CTR;
            player_y <= Y_CTR;
            lives    <= '0;
            score    <= '0;
            inv_cnt  <= '0;
            div_cnt  <= '0;
            invuln   <= 1'b0;
            new_game <= 1'b0;
        end else begin
            state_r  <= state_n;
            player_x <= x_n;
            player_y <= y_n;
            lives    <= lives_n;
            score    <= score_n;
            inv_cnt  <= inv_n;
            div_cnt  <= div_n;
            invuln   <= (inv_n != '0);
            new_game <= new_game_n;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios then random stimulus vs a behavioural model.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int X_MAX    = 624;
    localparam int Y_MAX    = 464;
    localparam int X_CTR    = 312;
    localparam int Y_CTR    = 232;
    localparam int STEP     = 4;
    localparam int MOVE_DIV = 2;
    localparam int LIVES    = 3;
    localparam int INVULN   = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_w = 1'b0, key_a = 1'b0, key_s = 1'b0, key_d = 1'b0;
    logic key_esc = 1'b0, key_enter = 1'b0, frame_tick = 1'b0, hit = 1'b0;
    logic [1:0]  state;
    logic [9:0]  player_x, player_y;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        invuln, new_game;

    game_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_w      (key_w),
        .key_a      (key_a),
        .key_s      (key_s),
        .key_d      (key_d),
        .key_esc    (key_esc),
        .key_enter  (key_enter),
        .frame_tick (frame_tick),
        .hit        (hit),
        .state      (state),
        .player_x   (player_x),
        .player_y   (player_y),
        .lives      (lives),
        .score      (score),
        .invuln     (invuln),
        .new_game   (new_game)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: game state as plain integers, frames counted since the last move.
    int m_state, m_x, m_y, m_lives, m_score, m_inv, m_frames;
    bit m_new_game;
    bit m_prev_esc   = 1'b1;
    bit m_prev_enter = 1'b1;

    function automatic int move(input int p, input bit dec, input bit inc, input int lim);
        int n;
        n = p + (inc ? STEP : 0) - (dec ? STEP : 0);
`ifdef GAME_CTRL_WRAP_EN
        if (n < 0)        n = lim + n;
        else if (n > lim) n = n - lim;
`else
        if (n < 0)        n = 0;
        else if (n > lim) n = lim;
`endif
        return n;
    endfunction

    task automatic model_step();
        bit esc_p, ent_p, hit_ok;
        int nxt;
        esc_p = key_esc && !m_prev_esc;
        ent_p = key_enter && !m_prev_enter;
        m_prev_esc   = key_esc;
        m_prev_enter = key_enter;
        m_new_game   = 1'b0;
        if (rst) begin
            m_state = MENU; m_x = X_CTR; m_y = Y_CTR;
            m_lives = 0; m_score = 0; m_inv = 0; m_frames = 0;
            m_prev_esc = 1'b1; m_prev_enter = 1'b1;
        end else begin
            case (m_state)
                MENU: if (ent_p) begin
                    m_state = PLAY; m_x = X_CTR; m_y = Y_CTR; m_lives = LIVES;
                    m_score = 0; m_inv = 0; m_frames = 0; m_new_game = 1'b1;
                end
                PLAY: begin
                    hit_ok = hit && (m_inv == 0);
                    nxt = PLAY;
                    if (hit_ok) m_lives = m_lives - 1;
                    if (hit_ok && m_lives == 0) nxt = OVER;
                    else if (esc_p)             nxt = PAUSE;
                    if (frame_tick) begin
                        if (m_score < 65535) m_score = m_score + 1;
                        if (m_inv > 0) m_inv = m_inv - 1;
                        m_frames = m_frames + 1;
                        if (m_frames == MOVE_DIV) begin
                            m_frames = 0;
                            m_x = move(m_x, key_a, key_d, X_MAX);
                            m_y = move(m_y, key_w, key_s, Y_MAX);
                        end
                    end
                    if (hit_ok) m_inv = INVULN;
                    m_state = nxt;
                end
                PAUSE: if (esc_p || ent_p) m_state = PLAY;
                default: if (esc_p || ent_p) m_state = MENU;
            endcase
        end
    endtask

    task automatic compare_all();
        check("state",    state,    m_state);
        check("player_x", player_x, m_x);
        check("player_y", player_y, m_y);
        check("lives",    lives,    m_lives);
        check("score",    score,    m_score);
        check("invuln",   invuln,   (m_inv != 0));
        check("new_game", new_game, m_new_game);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; cycle();
            frame_tick = 1'b0; cycle();
        end
    endtask

    initial begin
        // Reset with enter held, keep holding: no start.
        rst = 1'b1; key_enter = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle(); cycle();
        check("held_enter_no_start", state, MENU);
        key_enter = 1'b0; cycle();
        key_enter = 1'b1; cycle();
        check("start_state", state, PLAY);
        check("start_pulse", new_game, 1);
        check("start_lives", lives, 3);
        check("start_x", player_x, 312);
        check("start_y", player_y, 232);
        key_enter = 1'b0; cycle();
        check("pulse_once", new_game, 0);

        // Move right, then clamp/wrap at the left edge.
        key_d = 1'b1; ticks(10);
        check("right_x", player_x, 332);
        check("right_score", score, 10);
        key_d = 1'b0; key_a = 1'b1; ticks(166);
        check("left_edge_x", player_x, 0);
        ticks(2);
`ifdef GAME_CTRL_WRAP_EN
        check("left_wrap_x", player_x, 620);
`else
        check("left_clamp_x", player_x, 0);
`endif
        key_a = 1'b0;

        // Opposing vertical keys cancel.
        key_w = 1'b1; key_s = 1'b1; ticks(4);
        check("ws_cancel_y", player_y, 232);
        key_w = 1'b0; key_s = 1'b0;

        // Hits and invulnerability window.
        hit = 1'b1; cycle(); hit = 1'b0;
        check("hit1_lives", lives, 2);
        check("hit1_invuln", invuln, 1);
        ticks(5);
        hit = 1'b1; cycle(); hit = 1'b0;
        check("hit_ignored_lives", lives, 2);
        ticks(54);
        check("invuln_still_on", invuln, 1);
        ticks(1);
        check("invuln_expired", invuln, 0);
        hit = 1'b1; cycle(); hit = 1'b0;
        check("hit2_lives", lives, 1);
        ticks(60);

        // Last life with a same-cycle esc press goes to OVER.
        hit = 1'b1; key_esc = 1'b1; cycle(); hit = 1'b0;
        check("over_state", state, OVER);
        check("over_lives", lives, 0);
        key_esc = 1'b0; cycle();
        key_enter = 1'b1; cycle(); key_enter = 1'b0;
        check("back_to_menu", state, MENU);
        check("score_held", score, 302);
        cycle();
        key_enter = 1'b1; cycle(); key_enter = 1'b0;
        check("restart_score", score, 0);
        check("restart_pulse", new_game, 1);

        // Pause freezes everything.
        cycle();
        key_esc = 1'b1; cycle(); key_esc = 1'b0;
        check("pause_state", state, PAUSE);
        key_d = 1'b1; ticks(4);
        hit = 1'b1; frame_tick = 1'b1; cycle(); hit = 1'b0; frame_tick = 1'b0;
        check("pause_score", score, 0);
        check("pause_lives", lives, 3);
        check("pause_x", player_x, 312);
        key_d = 1'b0;
        key_enter = 1'b1; cycle(); key_enter = 1'b0;
        check("resume_state", state, PLAY);
        ticks(3);

        // Reset mid-game.
        rst = 1'b1; cycle(); rst = 1'b0;
        check("midgame_reset_state", state, MENU);
        check("midgame_reset_lives", lives, 0);

        // Randomised stimulus against the model.
        for (int i = 0; i < 6000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            hit        = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) key_w = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) key_a = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) key_s = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) key_d = $urandom_range(0, 1);
            if ($urandom_range(0, 11) == 0) key_esc = $urandom_range(0, 1);
            if ($urandom_range(0, 11) == 0) key_enter = $urandom_range(0, 1);
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
